// File: rtl/display_scanner.sv
// display_scanner: binary-to-BCD converter (sequential double-dabble) feeding a
// time-multiplexed 7-segment digit scan. One BCD digit, a blank flag and the
// active-low anode enables are presented per scan slot to a shared decoder.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above the
// most significant nonzero digit (digit 0 is always shown).
module display_scanner #(
  parameter int DATA_W      = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [3:0]            bcd_out,
  output logic                  blank_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Largest value representable in NUM_DIGITS decimal digits.
  function automatic logic [63:0] max_decimal(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_decimal(NUM_DIGITS);

  typedef enum logic {
    S_IDLE,
    S_CONVERT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_shift;
  logic                w_done;
  logic                w_ovf;

  logic [DATA_W-1:0]   r_bin;
  logic [BW-1:0]       r_bcd;
  logic [BW-1:0]       w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_overflow;
  logic [BW-1:0]       r_disp;
  logic                r_valid;

  logic [RW-1:0]       r_ref;
  logic [IW-1:0]       r_idx;
  logic [3:0]          r_bcd_out;
  logic                r_blank_out;
  logic [NUM_DIGITS-1:0] r_an_out;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [NUM_DIGITS-1:0] w_an_sel;

  assign busy      = (r_state == S_CONVERT);
  assign overflow  = r_overflow;
  assign bcd_out   = r_bcd_out;
  assign blank_out = r_blank_out;
  assign an_out    = r_an_out;

  assign w_ovf   = ({{(64 - DATA_W){1'b0}}, value_in} > MAX_VAL);
  assign w_digit = r_disp[{r_idx, 2'b00} +: 4];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and datapath strobes; load is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (r_cnt == CW'(DATA_W)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Double-dabble add-3 step applied to every BCD nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture, shift {bcd,bin} left, publish to display reg.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_disp     <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bin      <= value_in;
        r_bcd      <= '0;
        r_cnt      <= '0;
        r_overflow <= w_ovf;
      end
      if (w_shift) begin
        r_bcd <= {w_adj[BW-2:0], r_bin[DATA_W-1]};
        r_bin <= {r_bin[DATA_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_disp  <= r_bcd;
        r_valid <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // w_lz[i] = digit i and every digit above it are zero.
  always_comb begin
    logic w_run;
    w_run = 1'b1;
    w_lz  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_run = w_run && (r_disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      w_lz[NUM_DIGITS-1-k] = w_run;
    end
  end

  assign w_blank = !r_valid || r_overflow || (w_lz[r_idx] && (r_idx != '0));
`else
  assign w_blank = !r_valid || r_overflow;
`endif

  // One-hot-low anode pattern for the digit currently indexed.
  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

  // Free-running scan: at each refresh wrap present digit r_idx, then advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ref       <= '0;
      r_idx       <= '0;
      r_bcd_out   <= '0;
      r_blank_out <= 1'b1;
      r_an_out    <= '1;
    end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
      r_ref       <= '0;
      r_idx       <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_bcd_out   <= w_digit;
      r_blank_out <= w_blank;
      r_an_out    <= w_an_sel;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Testbench for display_scanner: directed loads, scoreboard of expected scan slots
// checked by an independent monitor on every anode change.
module tb_display_scanner;

  localparam int DATA_W      = 14;
  localparam int NUM_DIGITS  = 4;
  localparam int REFRESH_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_MASK_7 = 4'b1110;
`else
  localparam logic [3:0] LZ_MASK_7 = 4'b0000;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] value_in = '0;
  logic              busy;
  logic              overflow;
  logic [3:0]        bcd_out;
  logic              blank_out;
  logic [3:0]        an_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       blank;
    bit         chk_bcd;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  display_scanner #(
    .DATA_W      (DATA_W),
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .load      (load),
    .busy      (busy),
    .overflow  (overflow),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .an_out    (an_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every anode change is a new scan slot; compare against the next expectation.
  initial begin
    logic [3:0] prev;
    exp_t       e;
    prev = 4'bxxxx;
    forever begin
      @(negedge clk);
      if (an_out !== prev) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          n_tests++;
          if (an_out !== e.an || blank_out !== e.blank || (e.chk_bcd && bcd_out !== e.bcd)) begin
            n_fail++;
            $display("FAIL %s: an=%b bcd=%0d blank=%b, expected an=%b bcd=%0d blank=%b",
                     e.name, an_out, bcd_out, blank_out, e.an, e.bcd, e.blank);
          end
        end
        prev = an_out;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait idle", (n < 200), 1);
  endtask

  task automatic do_load(input logic [DATA_W-1:0] val, input logic exp_ovf, input string name);
    int n;
    wait_idle();
    value_in = val;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check({name, " busy after accept"}, busy, 1);
    check({name, " overflow"}, overflow, exp_ovf);
    n = 0;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1 || n >= 100) break;
      n++;
    end
    check({name, " busy cycles"}, n, 15);
  endtask

  // Sync to the digit-3 slot, then expect one full scan of digits 0..3.
  task automatic expect_scan(input logic [15:0] bcd, input logic [3:0] blank_mask, input string name);
    int   n;
    exp_t e;
    n = 0;
    while (an_out === 4'b0111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (an_out !== 4'b0111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check({name, " scan sync"}, 0, 1);
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      e.an      = ~(4'b0001 << i);
      e.bcd     = bcd[4*i +: 4];
      e.blank   = blank_mask[i];
      e.chk_bcd = !blank_mask[i];
      e.name    = $sformatf("%s d%0d", name, i);
      sb_q.push_back(e);
    end
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check({name, " scan drain"}, sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: reset state and first wrap
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst overflow", overflow, 0);
    check("rst blank", blank_out, 1);
    check("rst an", an_out, 4'b1111);
    check("rst bcd", bcd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("an before first wrap", an_out, 4'b1111);
    @(posedge clk);
    #1;
    check("an first wrap", an_out, 4'b1110);
    check("blank first wrap", blank_out, 1);

    // 2: basic conversion
    do_load(14'd1234, 1'b0, "ld1234");
    expect_scan(16'h1234, 4'b0000, "scan1234");

    // 3: small values, leading-zero handling
    do_load(14'd7, 1'b0, "ld7");
    expect_scan(16'h0007, LZ_MASK_7, "scan7");
    do_load(14'd0, 1'b0, "ld0");
    expect_scan(16'h0000, LZ_MASK_7, "scan0");

    // 4: overflow and the largest in-range value
    do_load(14'd12000, 1'b1, "ld12000");
    expect_scan(16'h0000, 4'b1111, "scan12000");
    do_load(14'd9999, 1'b0, "ld9999");
    expect_scan(16'h9999, 4'b0000, "scan9999");

    // 5: loads while busy (mid-conversion and completion edge) are ignored
    wait_idle();
    value_in = 14'd1234;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("ign busy k%0d", k), busy, 1);
      load     = (k == 5 || k == 15);
      value_in = 14'd5678;
    end
    @(negedge clk);
    load = 1'b0;
    check("no accept on completion", busy, 0);
    @(negedge clk);
    check("still idle", busy, 0);
    expect_scan(16'h1234, 4'b0000, "scan_ign");
    do_load(14'd5678, 1'b0, "ld5678");
    expect_scan(16'h5678, 4'b0000, "scan5678");

    // 6: reset aborts a conversion
    wait_idle();
    value_in = 14'd4321;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("abort busy", busy, 1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort rst busy", busy, 0);
    check("abort rst an", an_out, 4'b1111);
    check("abort rst blank", blank_out, 1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_scan(16'h0000, 4'b1111, "scan_abort");
    check("abort stays idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
